// File: rtl/idct_sched.sv
// Two-requester block scheduler for a shared 8x8 IDCT pipeline: round-robin
// arbitration at block boundaries, contiguous block streaming, credit limiting and owner tagging.
module idct_sched #(
  parameter int BLK_LEN      = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_mode,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_mode,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        core_start,
  output logic [1:0]  core_idct,
  output logic [15:0] core_x,
  input  logic        core_out_valid,
  input  logic [15:0] core_z,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_owner,
  output logic        out_last,
  output logic        err_underrun,
  output logic        err_spurious
);

  localparam int BW = $clog2(BLK_LEN);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLK_LEN - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_INFLIGHT - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]  req_valid;
  logic [1:0]  req_mode [2];
  logic [15:0] req_data [2];
  logic [1:0]  ready_vec;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_mode[0] = req0_mode;
  assign req_mode[1] = req1_mode;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  logic [BW-1:0] beat_reg;
  logic          grant_id_reg;
  logic          last_grant_reg;
  logic [1:0]    mode_reg;
  logic          core_start_reg;
  logic [1:0]    core_idct_reg;
  logic [15:0]   core_x_reg;

  logic [CW-1:0]           inflight_reg;
  logic [PW-1:0]           wr_ptr_reg;
  logic [PW-1:0]           rd_ptr_reg;
  logic [MAX_INFLIGHT-1:0] owner_mem_reg;

  logic [BW-1:0] out_beat_reg;
  logic          out_valid_reg;
  logic [15:0]   out_data_reg;
  logic          out_owner_reg;
  logic          out_last_reg;
  logic          err_spurious_reg;

  logic          grant_valid;
  logic          grant_sel;
  logic          cur_valid;
  logic          underrun;
  logic          pop;
  logic          fifo_avail;
  logic          out_accept;
  logic [PW-1:0] head_ptr;

  function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_valid = (state_reg == IDLE) && (inflight_reg < MAX_CNT) && (req_valid != 2'b00);
    grant_sel   = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = BURST;
      BURST:   if (beat_reg == LAST_BEAT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_valid = req_valid[grant_id_reg];
    underrun  = (state_reg == BURST) && !cur_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == BURST) && (grant_id_reg == 1'(gi));
    end
  endgenerate

  assign req0_ready   = ready_vec[0];
  assign req1_ready   = ready_vec[1];
  assign err_underrun = underrun;

  // A burst sample is consumed every beat; a missing sample is replaced by zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg       <= '0;
      grant_id_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
      mode_reg       <= 2'b00;
      core_start_reg <= 1'b0;
      core_idct_reg  <= 2'b00;
      core_x_reg     <= '0;
    end else begin
      if (grant_valid) begin
        grant_id_reg   <= grant_sel;
        last_grant_reg <= grant_sel;
        mode_reg       <= req_mode[grant_sel];
        beat_reg       <= '0;
      end
      if (state_reg == BURST) begin
        beat_reg       <= beat_reg + 1'b1;
        core_x_reg     <= cur_valid ? req_data[grant_id_reg] : '0;
        core_start_reg <= (beat_reg == '0);
        core_idct_reg  <= mode_reg;
      end else begin
        core_x_reg     <= '0;
        core_start_reg <= 1'b0;
        core_idct_reg  <= 2'b00;
      end
    end
  end

  assign core_start = core_start_reg;
  assign core_idct  = core_idct_reg;
  assign core_x     = core_x_reg;

  // The owner entry retires in the cycle out_last is shown, so a block that
  // starts right behind it must already see the next entry as head.
  always_comb begin
    pop        = out_last_reg;
    head_ptr   = out_last_reg ? slot_inc(rd_ptr_reg) : rd_ptr_reg;
    fifo_avail = out_last_reg ? (inflight_reg > CW'(1)) : (inflight_reg != '0);
    out_accept = core_out_valid && fifo_avail;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      owner_mem_reg <= '0;
    end else begin
      if (grant_valid) begin
        owner_mem_reg[wr_ptr_reg] <= grant_sel;
        wr_ptr_reg                <= slot_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= slot_inc(rd_ptr_reg);
      end
      case ({grant_valid, pop})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_beat_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_owner_reg    <= 1'b0;
      out_last_reg     <= 1'b0;
      err_spurious_reg <= 1'b0;
    end else begin
      out_valid_reg    <= out_accept;
      out_data_reg     <= out_accept ? core_z : '0;
      out_owner_reg    <= out_accept ? owner_mem_reg[head_ptr] : 1'b0;
      out_last_reg     <= out_accept && (out_beat_reg == LAST_BEAT);
      err_spurious_reg <= core_out_valid && !fifo_avail;
      if (out_accept) begin
        out_beat_reg <= out_beat_reg + 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_owner    = out_owner_reg;
  assign out_last     = out_last_reg;
  assign err_spurious = err_spurious_reg;

endmodule

// File: tb/tb_idct_sched.sv
// Directed bench for idct_sched: single block, contention, credit limit,
// underrun, spurious output, coincident grant/retire and mid-burst reset.
module tb_idct_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_mode, req1_mode;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        core_start;
  logic [1:0]  core_idct;
  logic [15:0] core_x;
  logic        core_out_valid;
  logic [15:0] core_z;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_owner;
  logic        out_last;
  logic        err_underrun;
  logic        err_spurious;

  int n_cmp = 0;
  int n_bad = 0;

  idct_sched dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_mode      (req0_mode),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_mode      (req1_mode),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .core_start     (core_start),
    .core_idct      (core_idct),
    .core_x         (core_x),
    .core_out_valid (core_out_valid),
    .core_z         (core_z),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_owner      (out_owner),
    .out_last       (out_last),
    .err_underrun   (err_underrun),
    .err_spurious   (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_mode = 2'b00; req0_data = '0;
    req1_valid = 1'b0; req1_mode = 2'b00; req1_data = '0;
    core_out_valid = 1'b0; core_z = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) adv();
    rst = 1'b0;
  endtask

  task automatic chk_in(input string p, input int c, input logic r0, input logic r1,
                        input logic st, input logic [1:0] idct, input logic [15:0] x,
                        input logic und);
    chk($sformatf("%s c%0d req0_ready", p, c), req0_ready, r0);
    chk($sformatf("%s c%0d req1_ready", p, c), req1_ready, r1);
    chk($sformatf("%s c%0d core_start", p, c), core_start, st);
    chk($sformatf("%s c%0d core_idct", p, c), core_idct, idct);
    chk($sformatf("%s c%0d core_x", p, c), core_x, x);
    chk($sformatf("%s c%0d err_underrun", p, c), err_underrun, und);
  endtask

  task automatic chk_out(input string p, input int c, input logic ov, input logic [15:0] od,
                         input logic oo, input logic ol, input logic sp);
    chk($sformatf("%s c%0d out_valid", p, c), out_valid, ov);
    if (ov) begin
      chk($sformatf("%s c%0d out_data", p, c), out_data, od);
      chk($sformatf("%s c%0d out_owner", p, c), out_owner, oo);
    end
    chk($sformatf("%s c%0d out_last", p, c), out_last, ol);
    chk($sformatf("%s c%0d err_spurious", p, c), err_spurious, sp);
  endtask

  initial begin
    logic        r0, r1, st, ov, oo, ol, und;
    logic [1:0]  idct;
    logic [15:0] x, od;
    int          p, idx;

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (2) adv();
    @(negedge clk);
    chk_in("RST", 0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
    chk_out("RST", 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("RST inflight", 32'(dut.inflight_reg), 32'd0);
    adv();
    rst = 1'b0;

    // A: single req0 block, output return, then req1 granted in the out_last cycle
    for (int c = 0; c <= 200; c++) begin
      req0_valid = (c <= 64); req0_mode = 2'b01; req0_data = (c == 0) ? 16'd1 : 16'(c);
      req1_valid = (c >= 134 && c <= 198); req1_mode = 2'b10; req1_data = 16'(16'hF000 + c);
      core_out_valid = (c >= 70 && c <= 133); core_z = 16'(c + 300);
      @(negedge clk);
      r0 = (c >= 1 && c <= 64);
      r1 = (c >= 135 && c <= 198);
      st = (c == 2 || c == 136);
      idct = (c >= 2 && c <= 65) ? 2'b01 : (c >= 136 && c <= 199) ? 2'b10 : 2'b00;
      x = (c >= 2 && c <= 65) ? 16'(c - 1) : (c >= 136 && c <= 199) ? 16'(16'hF000 + c - 1) : 16'h0000;
      chk_in("A", c, r0, r1, st, idct, x, 1'b0);
      ov = (c >= 71 && c <= 134);
      chk_out("A", c, ov, 16'(c - 1 + 300), 1'b0, (c == 134), 1'b0);
      if (c == 66 || c == 134 || c == 135 || c == 200)
        chk($sformatf("A c%0d inflight", c), 32'(dut.inflight_reg), 32'd1);
      adv();
    end
    $display("[tb] single block + coincident grant/retire done, %0d compared", n_cmp);

    // Spurious core output with nothing in flight
    do_reset();
    for (int k = 0; k <= 2; k++) begin
      core_out_valid = (k == 0); core_z = 16'h1234;
      @(negedge clk);
      chk_out("S", k, 1'b0, 16'h0000, 1'b0, 1'b0, (k == 1));
      adv();
    end
    core_out_valid = 1'b0;
    $display("[tb] spurious output done, %0d compared", n_cmp);

    // B: contention, both requesters continuously valid; four blocks 0,1,0,1
    for (int c = 0; c <= 262; c++) begin
      req0_valid = (c <= 259); req0_mode = 2'b10; req0_data = 16'(c);
      req1_valid = (c <= 259); req1_mode = 2'b11; req1_data = 16'(0 - c);
      core_out_valid = (c >= 60 && c <= 187); core_z = 16'(c * 3);
      @(negedge clk);
      r0 = 1'b0; r1 = 1'b0; st = 1'b0; idct = 2'b00; x = 16'h0000;
      if (c >= 1) begin
        p = (c - 1) % 65; idx = (c - 1) / 65;
        if (p < 64 && idx < 4) begin
          if (idx % 2 == 1) r1 = 1'b1; else r0 = 1'b1;
        end
      end
      if (c >= 2) begin
        p = (c - 2) % 65; idx = (c - 2) / 65;
        if (p < 64 && idx < 4) begin
          st = (p == 0);
          idct = (idx % 2 == 1) ? 2'b11 : 2'b10;
          x = (idx % 2 == 1) ? 16'(0 - (c - 1)) : 16'(c - 1);
        end
      end
      chk_in("B", c, r0, r1, st, idct, x, 1'b0);
      ov = (c >= 61 && c <= 188);
      oo = (c > 124);
      ol = (c == 124 || c == 188);
      chk_out("B", c, ov, 16'((c - 1) * 3), oo, ol, 1'b0);
      if (c == 130 || c == 195)
        chk($sformatf("B c%0d inflight", c), 32'(dut.inflight_reg), 32'd1);
      adv();
    end
    $display("[tb] contention done, %0d compared", n_cmp);

    // C: credit limit, underrun on req1 beat 10, release after out_last, reset on beat 30
    do_reset();
    for (int c = 0; c <= 262; c++) begin
      rst = (c == 246);
      req0_valid = (c <= 246); req0_mode = 2'b11; req0_data = 16'(c);
      req1_valid = ((c != 76) && (c <= 129)) || (c >= 249); req1_mode = 2'b01;
      req1_data = 16'(c + 500);
      core_out_valid = (c >= 150 && c <= 213); core_z = 16'(c + 1000);
      @(negedge clk);
      r0 = (c >= 1 && c <= 64) || (c >= 216 && c <= 246);
      r1 = (c >= 66 && c <= 129) || (c >= 250);
      st = (c == 2 || c == 67 || c == 217 || c == 251);
      und = (c == 76);
      if (c >= 2 && c <= 65) begin
        idct = 2'b11; x = 16'(c - 1);
      end else if (c >= 67 && c <= 130) begin
        idct = 2'b01; x = (c == 77) ? 16'h0000 : 16'(c - 1 + 500);
      end else if (c >= 217 && c <= 246) begin
        idct = 2'b11; x = 16'(c - 1);
      end else if (c >= 251) begin
        idct = 2'b01; x = 16'(c - 1 + 500);
      end else begin
        idct = 2'b00; x = 16'h0000;
      end
      chk_in("C", c, r0, r1, st, idct, x, und);
      ov = (c >= 151 && c <= 214);
      chk_out("C", c, ov, 16'(c - 1 + 1000), 1'b0, (c == 214), 1'b0);
      if (c == 150 || c == 216)
        chk($sformatf("C c%0d inflight", c), 32'(dut.inflight_reg), 32'd2);
      if (c == 215 || c == 250)
        chk($sformatf("C c%0d inflight", c), 32'(dut.inflight_reg), 32'd1);
      if (c == 247)
        chk($sformatf("C c%0d inflight", c), 32'(dut.inflight_reg), 32'd0);
      adv();
    end
    rst = 1'b0;
    $display("[tb] credit/underrun/reset done, %0d compared", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
